// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO words into PACK-lane beats, emitting on full beat, flush or idle timeout
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          rclk,
    input  logic                          rrst,
    input  logic                          rempty,
    input  logic [DATA_WIDTH-1:0]         rdata,
    output logic                          rinc,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH*PACK-1:0]    m_data,
    output logic [PACK-1:0]               m_keep,
    output logic [$clog2(PACK+1)-1:0]     lane_cnt
);
    localparam int CW = $clog2(PACK+1);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    logic [0:0] state;
    logic [7:0] idle;
    logic       fill;
    logic       partial;
    logic       timeout_hit;
    assign fill        = state == FILL;
    assign partial     = lane_cnt != '0;
    assign rinc        = fill && !rempty && !(flush && partial) && !rrst;
    // fires on the idle cycle that would bring the counter to TIMEOUT, so it never races a pop
    assign timeout_hit = fill && partial && rempty && idle == 8'(TIMEOUT-1);
    assign m_valid     = state == EMIT;
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state    <= FILL;
            m_data   <= '0;
            m_keep   <= '0;
            lane_cnt <= '0;
            idle     <= '0;
        end else if (fill) begin
            if (rinc) begin
                for (int i = 0; i < PACK; i++) begin
                    if (lane_cnt == CW'(i)) begin
                        m_data[i*DATA_WIDTH +: DATA_WIDTH] <= rdata;
                        m_keep[i] <= 1'b1;
                    end
                end
                lane_cnt <= lane_cnt + CW'(1);
                idle     <= '0;
                if (lane_cnt == CW'(PACK-1))
                    state <= EMIT;
            end else if ((flush && partial) || timeout_hit) begin
                state <= EMIT;
                idle  <= '0;
            end else if (partial && rempty) begin
                idle <= idle + 8'd1;
            end
        end else if (m_ready) begin
            state    <= FILL;
            m_data   <= '0;
            m_keep   <= '0;
            lane_cnt <= '0;
            idle     <= '0;
        end
    end
endmodule
